mole_round_scheduler: RTL and testbench

Round sequencer for the switch-reaction game. It picks a target LED and shows it for a level-dependent window. It judges the player's switch toggle as a hit or miss, keeps score and level, and ends the game after a fixed play time. It sits between the 1 ms tick generator / LFSR random source and the LED, 7-segment score and level displays.

---
 rtl/reaction_game_pkg.sv | 20 ++
 rtl/ms_window_timer.sv | 28 ++
 rtl/mole_round_scheduler.sv | 169 ++++++++++++++++
 tb/tb_mole_round_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_game_pkg.sv
// Shared types and constants for the reaction game round sequencer.
package reaction_game_pkg;

  // Round sequencer states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_SHOW      = 3'd2,
    ST_HIT       = 3'd3,
    ST_MISS      = 3'd4,
    ST_GAME_OVER = 3'd5
  } round_state_t;

  // Score display tops out at two decimal digits
  localparam int SCORE_MAX = 99;

  // Millisecond ticks per game-clock second
  localparam int MS_PER_SECOND = 1000;

endpackage

// File: rtl/ms_window_timer.sv
// Counts ms ticks up to a loadable limit and pulses done on the limit-th tick.
// Reused for the dark gap before a target and for the target show window.
module ms_window_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        ms_tick,
  input  logic [15:0] limit,
  output logic        done
);

  logic [15:0] count_reg;

  // done coincides with the tick that completes the window
  assign done = ms_tick && !clear && ((count_reg + 16'd1) == limit);

  // Tick counter; restarts after each completed window or on clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear || done) begin
      count_reg <= '0;
    end else if (ms_tick) begin
      count_reg <= count_reg + 16'd1;
    end
  end

endmodule

// File: rtl/mole_round_scheduler.sv
// Round sequencer for the switch-reaction game: picks targets, judges
// toggles as hits or misses, keeps score/level and runs the game clock.
module mole_round_scheduler
  import reaction_game_pkg::*;
#(
  parameter int LED_NUM        = 18,
  parameter int GAME_SECONDS   = 60,
  parameter int BASE_MS        = 1000,
  parameter int STEP_MS        = 80,
  parameter int GAP_MS         = 250,
  parameter int HITS_PER_LEVEL = 5,
  parameter int MAX_LEVEL      = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_tick,
  input  logic                       start,
  input  logic [LED_NUM-1:0]         switches,
  input  logic [$clog2(LED_NUM)-1:0] random_value,
  output logic [LED_NUM-1:0]         leds,
  output logic [6:0]                 user_score,
  output logic [3:0]                 level,
  output logic [5:0]                 game_seconds,
  output logic                       game_over
);

  localparam int IDX_W = $clog2(LED_NUM);
  localparam int HIT_W = $clog2(HITS_PER_LEVEL + 1);
  localparam logic [IDX_W-1:0] LED_NUM_IDX  = IDX_W'(LED_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(LED_NUM - 1);
  localparam logic [LED_NUM-1:0] ONE_HOT_LSB = {{(LED_NUM-1){1'b0}}, 1'b1};

  round_state_t       state_reg, state_next;
  logic [IDX_W-1:0]   target_reg, target_next;
  logic [LED_NUM-1:0] prev_sw_reg;
  logic [LED_NUM-1:0] leds_reg;
  logic [6:0]         score_reg;
  logic [3:0]         level_reg;
  logic [HIT_W-1:0]   hit_cnt_reg;
  logic [9:0]         ms_cnt_reg;
  logic [5:0]         sec_reg;

  logic [LED_NUM-1:0] toggle;
  logic               start_game;
  logic               in_play;
  logic               sec_wrap;
  logic               end_game;
  logic [15:0]        window_ms;
  logic [15:0]        timer_limit;
  logic               timer_clear;
  logic               timer_done;
  logic [IDX_W-1:0]   idx_raw;
  logic [IDX_W-1:0]   target_cand;

  assign toggle     = switches ^ prev_sw_reg;
  assign start_game = start && (state_reg == ST_IDLE || state_reg == ST_GAME_OVER);
  assign in_play    = (state_reg == ST_ARM) || (state_reg == ST_SHOW) ||
                      (state_reg == ST_HIT) || (state_reg == ST_MISS);
  assign sec_wrap   = in_play && ms_tick && (ms_cnt_reg == 10'(MS_PER_SECOND - 1));
  assign end_game   = sec_wrap && (sec_reg == 6'(GAME_SECONDS - 1));

  // Show window shrinks by a fixed step per level
  assign window_ms   = 16'(BASE_MS) - (16'(level_reg) * 16'(STEP_MS));
  assign timer_limit = (state_reg == ST_ARM) ? 16'(GAP_MS) : window_ms;
  assign timer_clear = !((state_reg == ST_ARM) || (state_reg == ST_SHOW));

  // Fold the random index into range, then step off a repeated target
  assign idx_raw     = (random_value >= LED_NUM_IDX) ? (random_value - LED_NUM_IDX) : random_value;
  assign target_cand = (idx_raw != target_reg) ? idx_raw :
                       (idx_raw == LAST_IDX)   ? '0 : (idx_raw + 1'b1);

  ms_window_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .ms_tick (ms_tick),
    .limit   (timer_limit),
    .done    (timer_done)
  );

  // Next state and target; game end overrides any round transition
  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    case (state_reg)
      ST_IDLE, ST_GAME_OVER: begin
        if (start) begin
          state_next  = ST_ARM;
          target_next = '0;
        end
      end
      ST_ARM: begin
        if (timer_done) begin
          state_next  = ST_SHOW;
          target_next = target_cand;
        end
      end
      ST_SHOW: begin
        if (toggle[target_reg])   state_next = ST_HIT;
        else if (|toggle)         state_next = ST_MISS;
        else if (timer_done)      state_next = ST_MISS;
      end
      ST_HIT, ST_MISS: state_next = ST_ARM;
      default: state_next = ST_IDLE;
    endcase
    if (end_game) state_next = ST_GAME_OVER;
  end

  // State, target, switch history and LED display registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      target_reg  <= '0;
      prev_sw_reg <= '0;
      leds_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      target_reg  <= target_next;
      prev_sw_reg <= switches;
      leds_reg    <= (state_next == ST_SHOW) ? (ONE_HOT_LSB << target_next) : '0;
    end
  end

  // Score, hit counter and level; a hit cut off by game end is not scored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_reg   <= '0;
      level_reg   <= '0;
      hit_cnt_reg <= '0;
    end else if (start_game) begin
      score_reg   <= '0;
      level_reg   <= '0;
      hit_cnt_reg <= '0;
    end else if (state_reg == ST_HIT && !end_game) begin
      if (score_reg != 7'(SCORE_MAX)) score_reg <= score_reg + 7'd1;
      if (hit_cnt_reg == HIT_W'(HITS_PER_LEVEL - 1)) begin
        hit_cnt_reg <= '0;
        if (level_reg != 4'(MAX_LEVEL)) level_reg <= level_reg + 4'd1;
      end else begin
        hit_cnt_reg <= hit_cnt_reg + 1'b1;
      end
    end
  end

  // Game clock: ms ticks to seconds while a game is in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_cnt_reg <= '0;
      sec_reg    <= '0;
    end else if (start_game) begin
      ms_cnt_reg <= '0;
      sec_reg    <= '0;
    end else if (in_play && ms_tick) begin
      if (sec_wrap) begin
        ms_cnt_reg <= '0;
        sec_reg    <= sec_reg + 6'd1;
      end else begin
        ms_cnt_reg <= ms_cnt_reg + 10'd1;
      end
    end
  end

  assign leds         = leds_reg;
  assign user_score   = score_reg;
  assign level        = level_reg;
  assign game_seconds = sec_reg;
  assign game_over    = (state_reg == ST_GAME_OVER);

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Randomized scoreboard bench for mole_round_scheduler.
module tb_mole_round_scheduler;

  localparam int LED_NUM = 18;
  localparam int GAME_TICKS = 60000;

  logic               clk = 1'b0;
  logic               reset;
  logic               ms_tick;
  logic               start;
  logic [LED_NUM-1:0] switches;
  logic [4:0]         random_value;
  logic [LED_NUM-1:0] leds;
  logic [6:0]         user_score;
  logic [3:0]         level;
  logic [5:0]         game_seconds;
  logic               game_over;

  mole_round_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .ms_tick      (ms_tick),
    .start        (start),
    .switches     (switches),
    .random_value (random_value),
    .leds         (leds),
    .user_score   (user_score),
    .level        (level),
    .game_seconds (game_seconds),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  typedef enum int {EXP_SHOW = 0, EXP_RESULT = 1, EXP_OVER = 2} exp_kind_t;
  typedef struct {
    exp_kind_t          kind;
    logic [LED_NUM-1:0] leds;
    int                 score;
    int                 level;
    int                 seconds;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;

  // Reference model state: game-level quantities only
  logic [LED_NUM-1:0] sw_state;
  int m_prev;
  int m_hits;
  int m_ticks;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int model_level();
    return (m_hits / 5 > 9) ? 9 : m_hits / 5;
  endfunction

  function automatic int model_score();
    return (m_hits > 99) ? 99 : m_hits;
  endfunction

  function automatic int model_window();
    return 1000 - 80 * model_level();
  endfunction

  function automatic int model_target(input int rv);
    int idx;
    idx = rv % LED_NUM;
    if (idx == m_prev) idx = (idx + 1) % LED_NUM;
    return idx;
  endfunction

  task automatic push(input exp_kind_t k, input int tgt, input int secs);
    exp_t e;
    logic [LED_NUM-1:0] one;
    one = 1;
    e.kind    = k;
    e.leds    = (k == EXP_SHOW) ? (one << tgt) : '0;
    e.score   = model_score();
    e.level   = model_level();
    e.seconds = secs;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic t, input logic st, input logic [4:0] rv);
    ms_tick      = t;
    start        = st;
    switches     = sw_state;
    random_value = rv;
    @(posedge clk);
    #1;
    if (t) m_ticks++;
  endtask

  // Dark gap: 250 ticks, with occasional early toggles and ignored start presses
  task automatic arm_phase(input logic [4:0] rv, output int tgt);
    int noise_at;
    int start_at;
    tgt = model_target(int'(rv));
    m_prev = tgt;
    push(EXP_SHOW, tgt, 0);
    noise_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 240)) : -1;
    start_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 240)) : -1;
    for (int i = 0; i < 250; i++) begin
      if (i == noise_at) sw_state[$urandom_range(0, LED_NUM - 1)] ^= 1'b1;
      step(1'b1, (i == start_at), rv);
    end
  endtask

  // action: 0 timeout, 1 toggle on expiry tick, 2 hit, 3 wrong switch
  task automatic play_round(input logic [4:0] rv, input int m, input int action, input int other);
    int tgt;
    int o;
    bit hit;
    arm_phase(rv, tgt);
    hit = 0;
    case (action)
      0: repeat (m) step(1'b1, 1'b0, rv);
      1: begin
        repeat (m - 1) step(1'b1, 1'b0, rv);
        sw_state[tgt] ^= 1'b1;
        step(1'b1, 1'b0, rv);
        hit = 1;
      end
      2: begin
        repeat (m) step(1'b1, 1'b0, rv);
        sw_state[tgt] ^= 1'b1;
        if (other >= 0 && other != tgt) sw_state[other] ^= 1'b1;
        step(1'b0, 1'b0, rv);
        hit = 1;
      end
      default: begin
        repeat (m) step(1'b1, 1'b0, rv);
        o = (other == tgt) ? (tgt + 1) % LED_NUM : other;
        sw_state[o] ^= 1'b1;
        step(1'b0, 1'b0, rv);
      end
    endcase
    if (hit) m_hits++;
    push(EXP_RESULT, 0, 0);
    step(1'b0, 1'b0, rv);
  endtask

  // Monitor: pops one expectation per observed DUT event
  initial begin : monitor
    logic [LED_NUM-1:0] prev_leds;
    logic prev_go;
    exp_t e;
    prev_leds = '0;
    prev_go = 1'b0;
    forever begin
      @(negedge clk);
      if (game_over === 1'b1 && prev_go !== 1'b1) begin
        if (sb_q.size() == 0) check("sb_underflow_over", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          check("over_kind", EXP_OVER, e.kind);
          check("over_score", 32'(user_score), e.score);
          check("over_level", 32'(level), e.level);
          check("over_seconds", 32'(game_seconds), e.seconds);
          check("over_leds", 32'(leds), 32'(e.leds));
        end
      end else if (leds !== '0 && prev_leds === '0) begin
        if (sb_q.size() == 0) check("sb_underflow_show", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          check("show_kind", EXP_SHOW, e.kind);
          check("show_leds", 32'(leds), 32'(e.leds));
        end
      end else if (leds === '0 && prev_leds !== '0) begin
        if (sb_q.size() == 0) check("sb_underflow_result", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          check("result_kind", EXP_RESULT, e.kind);
          @(negedge clk);
          check("result_score", 32'(user_score), e.score);
          check("result_level", 32'(level), e.level);
        end
      end
      prev_leds = leds;
      prev_go = game_over;
    end
  end

  initial begin : stimulus
    int budget;
    int w;
    int m;
    int len;
    int action;
    int tgt;
    logic [4:0] rv;

    reset = 1'b1;
    ms_tick = 1'b0;
    start = 1'b0;
    sw_state = '0;
    switches = '0;
    random_value = '0;
    m_prev = 0;
    m_hits = 0;
    m_ticks = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_score", 32'(user_score), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_seconds", 32'(game_seconds), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    reset = 1'b0;
    step(1'b0, 1'b0, 5'd0);
    step(1'b0, 1'b1, 5'd0);

    // Directed opening rounds
    play_round(5'd5, 10, 2, -1);           // target 5, hit
    play_round(5'd20, 0, 3, 7);            // target 2, wrong switch
    play_round(5'd20, model_window(), 0, 0); // repeated value -> target 3, timeout
    play_round(5'd5, 30, 3, 7);            // target 5, switch 7 -> miss
    for (int i = 0; i < 4; i++) play_round(5'($urandom_range(0, 31)), 5, 2, -1);
    play_round(5'($urandom_range(0, 31)), model_window(), 0, 0); // level 1: 920-tick expiry

    // Random rounds sized so the game ends on a hit in the final SHOW
    budget = GAME_TICKS - 251 - m_ticks;
    while (budget > 0) begin
      w = model_window();
      if (budget <= 250 + w) len = budget;
      else if ($urandom_range(0, 1) == 0)
        len = 250 + int'($urandom_range(0, (w < budget - 500) ? w : budget - 500));
      else
        len = 250 + int'($urandom_range(0, 20));
      m = len - 250;
      action = (m == w) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 3));
      play_round(5'($urandom_range(0, 31)), m, action, int'($urandom_range(0, LED_NUM - 1)));
      budget = GAME_TICKS - 251 - m_ticks;
    end

    // Final round: the hitting toggle lands on the last game tick
    rv = 5'($urandom_range(0, 31));
    arm_phase(rv, tgt);
    sw_state[tgt] ^= 1'b1;
    push(EXP_OVER, 0, 60);
    step(1'b1, 1'b0, rv);
    repeat (5) step(1'b0, 1'b0, rv);
    check("over_hold_score", 32'(user_score), 32'(model_score()));
    check("over_hold_state", 32'(game_over), 32'd1);

    // Restart clears the game and the previous target
    step(1'b0, 1'b1, 5'd0);
    m_hits = 0;
    m_prev = 0;
    m_ticks = 0;
    check("restart_score", 32'(user_score), 32'd0);
    check("restart_level", 32'(level), 32'd0);
    check("restart_seconds", 32'(game_seconds), 32'd0);
    check("restart_game_over", 32'(game_over), 32'd0);
    play_round(5'd18, 3, 2, -1);           // 18 folds to 0, equals cleared target -> 1

    // Asynchronous reset in the middle of SHOW
    arm_phase(5'd7, tgt);
    step(1'b1, 1'b0, 5'd7);
    step(1'b1, 1'b0, 5'd7);
    m_hits = 0;
    push(EXP_RESULT, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_leds", 32'(leds), 32'd0);
    check("async_rst_score", 32'(user_score), 32'd0);
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_seconds", 32'(game_seconds), 32'd0);
    check("async_rst_game_over", 32'(game_over), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) step(1'b0, 1'b0, 5'd0);

    check("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
